// File: rtl/capture_ctrl_pkg.sv
// capture_pkg: shared states, run-mode encodings and trig_cfg bit positions for capture_ctrl
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        DUMP_RD,
        DUMP_TX,
        DUMP_WAIT
    } cap_state_t;

    localparam logic [1:0] RUN_STOP   = 2'b00;
    localparam logic [1:0] RUN_NORMAL = 2'b01;
    localparam logic [1:0] RUN_AUTO   = 2'b10;

    localparam int CFG_DONE_BIT = 5;

endpackage

// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: dump request / byte handshake between dispatcher-UART side (master) and capture_ctrl (slave)
interface capture_ctrl_if;

    logic       start_dump;
    logic [1:0] dump_channel;
    logic       resp_sent;
    logic       send_dump;
    logic [7:0] dump_data;
    logic       dump_finished;

    modport master (
        output start_dump, dump_channel, resp_sent,
        input  send_dump, dump_data, dump_finished
    );

    modport slave (
        input  start_dump, dump_channel, resp_sent,
        output send_dump, dump_data, dump_finished
    );

endinterface

// File: rtl/capture_ctrl_sample_strobe.sv
// sample_strobe: one-clock strobe every 2^decimator enabled clocks; counter held at 0 while disabled
module sample_strobe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] decimator,
    output logic       smp
);

    logic [15:0] dec_cnt_q, dec_cnt_d;

    // strobe on the final count of the period, then restart from zero
    always_comb begin
        smp       = en && (dec_cnt_q == 16'((17'd1 << decimator) - 17'd1));
        dec_cnt_d = (!en || smp) ? 16'd0 : dec_cnt_q + 16'd1;
    end

    // decimation counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dec_cnt_q <= '0;
        else        dec_cnt_q <= dec_cnt_d;
    end

endmodule

// File: rtl/capture_ctrl.sv
// capture_ctrl: sample RAM sequencer - decimated circular capture around a trigger, then oldest-first UART dump.
// Optional forced trigger in auto run mode is built only when CAPTURE_AUTO_TRIG_EN is defined.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int DEPTH = 512,
`ifdef CAPTURE_AUTO_TRIG_EN
    parameter int AUTO_TIMEOUT = 65535,
`endif
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        trig_cfg,
    input  logic [3:0]        decimator,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              triggered,
    output logic              armed,
    output logic              set_capture_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ch1_rdata,
    input  logic [7:0]        ch2_rdata,
    input  logic [7:0]        ch3_rdata,
    capture_ctrl_if.slave     dif
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    cap_state_t        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] tp_q, tp_d;
    logic [ADDR_W-1:0] trace_end_q, trace_end_d;
    logic [ADDR_W:0]   smp_cnt_q, smp_cnt_d;
    logic [1:0]        chan_q, chan_d;
    logic [ADDR_W-1:0] last_wr;
    logic              smp, capturing, dumping, stop, auto_fire;
    logic              send_dump, dump_finished;
    logic              unused_cfg;

    function automatic logic [ADDR_W-1:0] nxt(input logic [ADDR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [ADDR_W-1:0] prv(input logic [ADDR_W-1:0] p);
        return (p == '0) ? LAST : p - 1'b1;
    endfunction

    sample_strobe u_strobe (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (capturing),
        .decimator (decimator),
        .smp       (smp)
    );

    assign capturing  = (state_q == PRE) || (state_q == ARMED) || (state_q == POST);
    assign dumping    = (state_q == DUMP_RD) || (state_q == DUMP_TX) || (state_q == DUMP_WAIT);
    assign stop       = (trig_cfg[1:0] == RUN_STOP);
    assign unused_cfg = ^trig_cfg[4:2];
    assign ram_we     = smp;
    assign armed      = (state_q == ARMED);
    assign ram_addr   = dumping ? rd_ptr_q : wr_ptr_q;
    // a write in the current cycle is the newest sample; otherwise the newest is one behind wr_ptr
    assign last_wr    = ram_we ? wr_ptr_q : prv(wr_ptr_q);

    assign dif.send_dump     = send_dump;
    assign dif.dump_finished = dump_finished;
    assign dif.dump_data     = !send_dump ? 8'h00 :
                               (chan_q == 2'b00) ? ch1_rdata :
                               (chan_q == 2'b01) ? ch2_rdata : ch3_rdata;

`ifdef CAPTURE_AUTO_TRIG_EN
    logic [15:0] auto_cnt_q, auto_cnt_d;

    // count strobes spent in ARMED; restarts on every ARMED entry
    always_comb begin
        auto_cnt_d = (state_q != ARMED) ? 16'd0 : auto_cnt_q + {15'd0, smp};
        auto_fire  = (state_q == ARMED) && (trig_cfg[1:0] == RUN_AUTO) && smp &&
                     (auto_cnt_q == 16'(AUTO_TIMEOUT - 1));
    end

    // auto-trigger timeout register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) auto_cnt_q <= '0;
        else        auto_cnt_q <= auto_cnt_d;
    end
`else
    assign auto_fire = 1'b0;
`endif

    // next-state and pulse outputs; dump request outranks a stop, which outranks normal sequencing
    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = ram_we ? nxt(wr_ptr_q) : wr_ptr_q;
        smp_cnt_d        = smp_cnt_q;
        tp_d             = tp_q;
        trace_end_d      = trace_end_q;
        rd_ptr_d         = rd_ptr_q;
        rd_cnt_d         = rd_cnt_q;
        chan_d           = chan_q;
        set_capture_done = 1'b0;
        send_dump        = 1'b0;
        dump_finished    = 1'b0;
        if (dif.start_dump && !dumping) begin
            state_d     = DUMP_RD;
            chan_d      = dif.dump_channel;
            trace_end_d = capturing ? last_wr : trace_end_q;
            rd_ptr_d    = nxt(trace_end_d);
            rd_cnt_d    = '0;
        end else if (capturing && stop) begin
            state_d     = IDLE;
            trace_end_d = last_wr;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stop && !trig_cfg[CFG_DONE_BIT]) begin
                        state_d   = PRE;
                        smp_cnt_d = '0;
                        wr_ptr_d  = '0;
                        tp_d      = ({1'b0, trig_pos} > {1'b0, LAST}) ? LAST : trig_pos;
                    end
                end
                PRE: begin
                    smp_cnt_d = smp_cnt_q + {{ADDR_W{1'b0}}, smp};
                    if ((smp_cnt_q == {1'b0, tp_q}) || (smp && (smp_cnt_q + 1'b1 == {1'b0, tp_q})))
                        state_d = ARMED;
                end
                ARMED: begin
                    if (triggered || auto_fire) begin
                        state_d   = POST;
                        smp_cnt_d = '0;
                    end
                end
                POST: begin
                    if (smp) begin
                        if (smp_cnt_q == {1'b0, LAST} - {1'b0, tp_q}) begin
                            set_capture_done = 1'b1;
                            trace_end_d      = wr_ptr_q;
                            state_d          = IDLE;
                        end else begin
                            smp_cnt_d = smp_cnt_q + 1'b1;
                        end
                    end
                end
                DUMP_RD: state_d = DUMP_TX;
                DUMP_TX: begin
                    send_dump = 1'b1;
                    state_d   = DUMP_WAIT;
                end
                DUMP_WAIT: begin
                    if (dif.resp_sent) begin
                        rd_ptr_d = nxt(rd_ptr_q);
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        if (rd_cnt_q == LAST) begin
                            dump_finished = 1'b1;
                            state_d       = IDLE;
                        end else begin
                            state_d = DUMP_RD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state, pointer and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_cnt_q    <= '0;
            tp_q        <= '0;
            trace_end_q <= '0;
            smp_cnt_q   <= '0;
            chan_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_cnt_q    <= rd_cnt_d;
            tp_q        <= tp_d;
            trace_end_q <= trace_end_d;
            smp_cnt_q   <= smp_cnt_d;
            chan_q      <= chan_d;
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed checks of capture sequencing, decimation, dump ordering and aborts
module tb_capture_ctrl;
    import capture_pkg::*;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    trig_cfg;
    logic [3:0]    decimator;
    logic [AW-1:0] trig_pos;
    logic          triggered;
    logic          armed;
    logic          set_capture_done;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ch1_rdata, ch2_rdata, ch3_rdata;

    int n_assert = 0;
    int n_fail   = 0;
    int nwe, narm, ndone, nfin, nsend;
    logic [23:0] we_pat;
    logic [AW-1:0] exp_addr;
    logic exp_auto;

    always #5 clk = ~clk;

    capture_ctrl_if dif ();

    capture_ctrl #(
        .DEPTH(512)
`ifdef CAPTURE_AUTO_TRIG_EN
        , .AUTO_TIMEOUT(16)
`endif
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .trig_cfg         (trig_cfg),
        .decimator        (decimator),
        .trig_pos         (trig_pos),
        .triggered        (triggered),
        .armed            (armed),
        .set_capture_done (set_capture_done),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ch1_rdata        (ch1_rdata),
        .ch2_rdata        (ch2_rdata),
        .ch3_rdata        (ch3_rdata),
        .dif              (dif)
    );

    function automatic logic [7:0] pat(input logic [1:0] ch, input logic [AW-1:0] a);
        return (ch == 2'b00) ? a[7:0] : (ch == 2'b01) ? (a[7:0] ^ 8'h5A) : ~a[7:0];
    endfunction

    // RAM read ports with one-cycle latency, contents a fixed function of address
    always @(posedge clk) begin
        ch1_rdata <= pat(2'b00, ram_addr);
        ch2_rdata <= pat(2'b01, ram_addr);
        ch3_rdata <= pat(2'b10, ram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_send(input string tag);
        int k = 0;
        while (dif.send_dump !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(dif.send_dump), 32'd1);
    endtask

    initial begin
        rst_n            = 1'b0;
        trig_cfg         = 6'b100001;
        decimator        = 4'd0;
        trig_pos         = '0;
        triggered        = 1'b0;
        dif.start_dump   = 1'b0;
        dif.dump_channel = 2'b00;
        dif.resp_sent    = 1'b0;
        tick(3);
        chk("rst_armed", 32'(armed), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_send_dump", 32'(dif.send_dump), 0);
        chk("rst_dump_data", 32'(dif.dump_data), 0);
        chk("rst_done", 32'(set_capture_done), 0);
        chk("rst_finished", 32'(dif.dump_finished), 0);
        rst_n = 1'b1;
        tick(1);

        // done bit set: capture must not start
        nwe = 0;
        repeat (20) begin
            nwe += 32'(ram_we);
            tick(1);
        end
        chk("done_bit_no_we", nwe, 0);

        // clear done bit, dec=3: writes every 8th clock, first on the 8th clock of PRE
        decimator = 4'd3;
        trig_pos  = 9'd100;
        trig_cfg  = 6'b000001;
        tick(1);
        for (int i = 0; i < 24; i++) begin
            we_pat[i] = ram_we;
            tick(1);
        end
        chk("dec3_we_pattern", 32'(we_pat), 32'h808080);
        chk("dec3_wr_addr", 32'(ram_addr), 3);

        // stop aborts capture; dump then starts after the last write (addr 2)
        trig_cfg = 6'b000000;
        tick(1);
        nwe = 0;
        repeat (5) begin
            nwe += 32'(ram_we);
            tick(1);
        end
        chk("stop_no_we", nwe, 0);
        dif.dump_channel = 2'b00;
        dif.start_dump   = 1'b1;
        tick(1);
        dif.start_dump = 1'b0;
        wait_send("stop_dump_send");
        chk("stop_dump_addr", 32'(ram_addr), 3);
        chk("stop_dump_data", 32'(dif.dump_data), 32'(pat(2'b00, 9'd3)));
        trig_cfg = 6'b100001;
        rst_n    = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // full capture: dec=0, trig_pos=100, 200 armed writes, then 412 post writes
        decimator = 4'd0;
        trig_pos  = 9'd100;
        trig_cfg  = 6'b000001;
        tick(1);
        nwe  = 0;
        narm = 0;
        for (int i = 0; i < 100; i++) begin
            nwe  += 32'(ram_we);
            narm += 32'(armed);
            tick(1);
        end
        chk("pre_writes", nwe, 100);
        chk("pre_not_armed", narm, 0);
        chk("armed_after_pre", 32'(armed), 1);
        for (int i = 0; i < 199; i++) begin
            nwe += 32'(ram_we);
            tick(1);
        end
        triggered = 1'b1;
        nwe += 32'(ram_we);
        tick(1);
        triggered = 1'b0;
        chk("post_entered", 32'(armed), 0);
        chk("writes_before_post", nwe, 300);
        ndone = 0;
        for (int i = 0; i < 411; i++) begin
            triggered = (i == 50);
            nwe   += 32'(ram_we);
            ndone += 32'(set_capture_done);
            tick(1);
        end
        triggered = 1'b0;
        chk("done_not_early", ndone, 0);
        chk("done_pulse", 32'(set_capture_done), 1);
        chk("last_write_addr", 32'(ram_addr), 199);
        nwe += 32'(ram_we);
        chk("total_writes", nwe, 712);
        trig_cfg = 6'b100001;
        tick(1);
        chk("done_one_cycle", 32'(set_capture_done), 0);
        nwe = 0;
        repeat (10) begin
            nwe += 32'(ram_we);
            tick(1);
        end
        chk("idle_after_done", nwe, 0);

        // dump channel 2, oldest first from 200, resp_sent 5 clocks after each byte
        dif.dump_channel = 2'b01;
        dif.start_dump   = 1'b1;
        tick(1);
        dif.start_dump = 1'b0;
        nfin = 0;
        for (int k = 0; k < 512; k++) begin
            exp_addr = AW'((200 + k) % 512);
            wait_send("dump_send");
            chk("dump_addr", 32'(ram_addr), 32'(exp_addr));
            chk("dump_data", 32'(dif.dump_data), 32'(pat(2'b01, exp_addr)));
            tick(5);
            if (k == 10) begin
                dif.start_dump   = 1'b1;
                dif.dump_channel = 2'b00;
            end
            dif.resp_sent = 1'b1;
            #1;
            if (k == 511) chk("dump_finished", 32'(dif.dump_finished), 1);
            else nfin += 32'(dif.dump_finished);
            tick(1);
            dif.resp_sent  = 1'b0;
            dif.start_dump = 1'b0;
        end
        chk("finished_not_early", nfin, 0);
        chk("finished_one_cycle", 32'(dif.dump_finished), 0);
        nsend = 0;
        repeat (10) begin
            nsend += 32'(dif.send_dump);
            tick(1);
        end
        chk("no_send_after_dump", nsend, 0);

        // auto mode: forced trigger after 16 armed strobes only when the feature is built
        decimator = 4'd0;
        trig_pos  = 9'd0;
        trig_cfg  = 6'b000010;
        tick(2);
        chk("auto_armed_entry", 32'(armed), 1);
        tick(15);
        chk("auto_armed_16", 32'(armed), 1);
        tick(1);
`ifdef CAPTURE_AUTO_TRIG_EN
        exp_auto = 1'b0;
`else
        exp_auto = 1'b1;
`endif
        chk("auto_timeout", 32'(armed), 32'(exp_auto));
        trig_cfg = 6'b100000;
        tick(1);
        chk("auto_stop_abort", 32'(armed), 0);

        // start_dump mid-POST: no done pulse, dump begins after the last write (addr 7)
        trig_pos = 9'd4;
        trig_cfg = 6'b000001;
        tick(1);
        tick(4);
        chk("short_armed", 32'(armed), 1);
        triggered = 1'b1;
        tick(1);
        triggered = 1'b0;
        chk("short_post", 32'(armed), 0);
        tick(2);
        dif.dump_channel = 2'b10;
        dif.start_dump   = 1'b1;
        chk("mid_post_we", 32'(ram_we), 1);
        chk("mid_post_addr", 32'(ram_addr), 7);
        tick(1);
        dif.start_dump = 1'b0;
        chk("abort_no_done", 32'(set_capture_done), 0);
        chk("abort_no_we", 32'(ram_we), 0);
        wait_send("abort_dump_send");
        chk("abort_dump_addr", 32'(ram_addr), 8);
        chk("abort_dump_data", 32'(dif.dump_data), 32'(pat(2'b10, 9'd8)));

        // reset mid-dump aborts silently
        trig_cfg = 6'b100001;
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dump_addr", 32'(ram_addr), 0);
        chk("rst_mid_dump_send", 32'(dif.send_dump), 0);
        chk("rst_mid_dump_fin", 32'(dif.dump_finished), 0);
        tick(2);
        rst_n = 1'b1;
        nsend = 0;
        repeat (10) begin
            tick(1);
            nsend += 32'(dif.send_dump) + 32'(dif.dump_finished) + 32'(ram_we);
        end
        chk("idle_after_rst", nsend, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
